matmul_job_ctrl: RTL

Sequencer that owns the pipelined parametrized matrix multiplier (matrix_mult) and presents it to the system as a streaming job engine. Accepts operands A and B as a row-major element stream, loads them into operand registers, clears and enables the multiplier for a fixed latency, captures the result matrix and streams C back out. One job runs at a time; status outputs report busy and completion.

---
 rtl/matmul_job_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/matmul_job_ctrl.sv
// Job sequencer for the matrix_mult core: streams operands in, runs the multiplier
// for a fixed latency, captures the result matrix and streams it back out.
module matmul_job_ctrl #(
    parameter int N        = 3,
    parameter int BitWidth = 8,
    parameter int LATENCY  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BitWidth-1:0]           in_a,
    input  logic [BitWidth-1:0]           in_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*BitWidth-1:0]         out_data,
    output logic                          out_last,
    output logic [N*N*BitWidth-1:0]       mm_a,
    output logic [N*N*BitWidth-1:0]       mm_b,
    input  logic [N*N*2*BitWidth-1:0]     mm_c,
    output logic                          mm_clear,
    output logic                          mm_enable,
    output logic                          busy,
    output logic                          done
);

    localparam int NN    = N * N;
    localparam int RW    = 2 * BitWidth;
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
    localparam int LAT_W = $clog2(LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
    localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN} state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [LAT_W-1:0]     r_lat;
    logic [BitWidth-1:0]  r_a [NN];
    logic [BitWidth-1:0]  r_b [NN];
    logic [RW-1:0]        r_c [NN];
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [RW-1:0]        r_out_data;
    logic                 r_out_last;
    logic                 r_mm_clear;
    logic                 r_mm_enable;
    logic                 r_busy;
    logic                 r_done;
    logic [IDX_W-1:0]     w_idx_nxt;

    assign w_idx_nxt = r_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_lat       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_mm_clear  <= 1'b0;
            r_mm_enable <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int k = 0; k < NN; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_c[k] <= '0;
            end
        end else begin
            r_mm_clear <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE, S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_a[r_idx] <= in_a;
                        r_b[r_idx] <= in_b;
                        r_busy     <= 1'b1;
                        if (r_idx == LAST_IDX) begin
                            r_idx      <= '0;
                            r_lat      <= '0;
                            r_in_ready <= 1'b0;
                            r_mm_clear <= 1'b1;
                            r_state    <= S_COMPUTE;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            r_state <= S_LOAD;
                        end
                    end
                end
                // Cycle 0 clears the core; cycles 1..LATENCY enable it; capture at the end of LATENCY.
                S_COMPUTE: begin
                    if (r_lat == LAT_END) begin
                        for (int k = 0; k < NN; k++) begin
                            r_c[k] <= mm_c[k*RW +: RW];
                        end
                        r_lat       <= '0;
                        r_mm_enable <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= mm_c[0 +: RW];
                        r_out_last  <= (LAST_IDX == '0);
                        r_state     <= S_DRAIN;
                    end else begin
                        r_lat       <= r_lat + LAT_W'(1);
                        r_mm_enable <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx       <= '0;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_idx      <= w_idx_nxt;
                            r_out_data <= r_c[w_idx_nxt];
                            r_out_last <= (w_idx_nxt == LAST_IDX);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mm_a = '0;
        mm_b = '0;
        for (int k = 0; k < NN; k++) begin
            mm_a[k*BitWidth +: BitWidth] = r_a[k];
            mm_b[k*BitWidth +: BitWidth] = r_b[k];
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign mm_clear  = r_mm_clear;
    assign mm_enable = r_mm_enable;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
